// File: rtl/consmax_pkg.sv
// rtl/consmax_pkg.sv - shared types, defaults and helpers for the consmax sequencer
package consmax_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_t;

  localparam int LUT_ENTRIES = 32;
  localparam int LUT_DATA    = 16;

  // Number of set bits in a vector of up to 32 bits.
  function automatic logic [6:0] popcount(input logic [31:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/consmax_credit_cnt.sv
// rtl/consmax_credit_cnt.sv - in-flight beat counter with saturate-at-zero underflow flag
module consmax_credit_cnt #(
  parameter int NUM_HEAD     = 8,
  parameter int MAX_INFLIGHT = 16,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_HEAD-1:0] issue,
  input  logic [NUM_HEAD-1:0] complete,
  output logic [CW-1:0]       count,
  output logic                err_underflow
);

  import consmax_pkg::*;

  localparam int SW = CW + 8;

  logic [SW-1:0] gross;
  logic [SW-1:0] done;
  logic          under;
  logic [CW-1:0] count_n;

  // Issues and completions of the same cycle net out before the zero floor is applied.
  always_comb begin
    gross   = SW'(count) + SW'(popcount(32'(issue)));
    done    = SW'(popcount(32'(complete)));
    under   = done > gross;
    count_n = under ? '0 : CW'(gross - done);
  end

  // Counter register; the underflow flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      count <= count_n;
      if (under) err_underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/consmax_seq_ctrl.sv
// rtl/consmax_seq_ctrl.sv - LUT load, credit-limited head issue and drain-before-reload sequencer
module consmax_seq_ctrl #(
  parameter int IDATA_BIT    = 8,
  parameter int CDATA_BIT    = 8,
  parameter int LUT_DATA     = consmax_pkg::LUT_DATA,
  parameter int LUT_ADDR     = IDATA_BIT >> 1,
  parameter int LUT_ENTRIES  = consmax_pkg::LUT_ENTRIES,
  parameter int GBUS_DATA    = 32,
  parameter int GBUS_WIDTH   = 4,
  parameter int NUM_HEAD     = 8,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            cfg_reload_req,
  input  logic [CDATA_BIT-1:0]            cfg_shift,
  input  logic [LUT_DATA-1:0]             lut_in_data,
  input  logic                            lut_in_valid,
  output logic                            lut_in_ready,
  input  logic [GBUS_DATA*NUM_HEAD-1:0]   head_data,
  input  logic [NUM_HEAD-1:0]             head_valid,
  output logic [NUM_HEAD-1:0]             head_ready,
  input  logic [GBUS_WIDTH*NUM_HEAD-1:0]  bus_odata_valid,
  output logic [CDATA_BIT-1:0]            cfg_consmax_shift,
  output logic [LUT_ADDR:0]               lut_waddr,
  output logic                            lut_wen,
  output logic [LUT_DATA-1:0]             lut_wdata,
  output logic [GBUS_DATA*NUM_HEAD-1:0]   idata,
  output logic [NUM_HEAD-1:0]             idata_valid,
  output logic                            lut_loaded,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                            err_underflow
);

  import consmax_pkg::*;

  localparam logic [LUT_ADDR:0] LAST_ADDR = (LUT_ADDR + 1)'(LUT_ENTRIES - 1);

  state_t                state;
  state_t                state_n;
  logic [LUT_ADDR:0]     addr;
  logic [CDATA_BIT-1:0]  pend_shift;
  logic                  lut_hs;
  logic                  credit_ok;
  logic [NUM_HEAD-1:0]   accept;
  logic [NUM_HEAD-1:0]   complete;
  logic                  unused_lanes;

  // Only lane 0 of each head signals beat completion; other lanes are ignored.
  always_comb begin
    complete = '0;
    for (int h = 0; h < NUM_HEAD; h++) begin
      complete[h] = bus_odata_valid[h*GBUS_WIDTH];
    end
  end

  assign unused_lanes = ^bus_odata_valid;
  assign credit_ok    = (32'(inflight) + 32'(NUM_HEAD)) <= 32'(MAX_INFLIGHT);

  consmax_credit_cnt #(
    .NUM_HEAD     (NUM_HEAD),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_credit (
    .clk           (clk),
    .rstn          (rstn),
    .issue         (accept),
    .complete      (complete),
    .count         (inflight),
    .err_underflow (err_underflow)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and handshake readies; all heads share one credit decision.
  always_comb begin
    state_n      = state;
    lut_in_ready = 1'b0;
    head_ready   = '0;
    case (state)
      IDLE:  if (cfg_reload_req) state_n = LOAD;
      LOAD: begin
        lut_in_ready = 1'b1;
        if (lut_in_valid && addr == LAST_ADDR) state_n = RUN;
      end
      RUN: begin
        head_ready = {NUM_HEAD{credit_ok}};
        if (cfg_reload_req) state_n = DRAIN;
      end
      DRAIN: if (inflight == '0 && idata_valid == '0) state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end

  assign lut_hs = lut_in_valid & lut_in_ready;
  assign accept = head_valid & head_ready;

  // LUT write pipeline, issue registers and shift/loaded bookkeeping on transitions.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr              <= '0;
      pend_shift        <= '0;
      cfg_consmax_shift <= '0;
      lut_wen           <= 1'b0;
      lut_waddr         <= '0;
      lut_wdata         <= '0;
      idata             <= '0;
      idata_valid       <= '0;
      lut_loaded        <= 1'b0;
    end else begin
      lut_wen <= lut_hs;
      if (lut_hs) begin
        lut_waddr <= addr;
        lut_wdata <= lut_in_data;
        addr      <= addr + 1'b1;
      end
      idata_valid <= accept;
      for (int h = 0; h < NUM_HEAD; h++) begin
        if (accept[h]) idata[h*GBUS_DATA +: GBUS_DATA] <= head_data[h*GBUS_DATA +: GBUS_DATA];
      end
      if (state == IDLE && state_n == LOAD) begin
        cfg_consmax_shift <= cfg_shift;
        addr              <= '0;
      end
      if (state == DRAIN && state_n == LOAD) begin
        cfg_consmax_shift <= pend_shift;
        addr              <= '0;
      end
      if (state == RUN && state_n == DRAIN) begin
        pend_shift <= cfg_shift;
        lut_loaded <= 1'b0;
      end
      if (state == LOAD && state_n == RUN) lut_loaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_consmax_seq_ctrl.sv
// tb/tb_consmax_seq_ctrl.sv - randomized self-checking bench for consmax_seq_ctrl
module tb_consmax_seq_ctrl;

  localparam int NH = 8;
  localparam int GD = 32;
  localparam int GW = 4;
  localparam int NE = 32;
  localparam int MAXI = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cfg_reload_req;
  logic [7:0]        cfg_shift;
  logic [15:0]       lut_in_data;
  logic              lut_in_valid;
  logic              lut_in_ready;
  logic [GD*NH-1:0]  head_data;
  logic [NH-1:0]     head_valid;
  logic [NH-1:0]     head_ready;
  logic [GW*NH-1:0]  bus_odata_valid;
  logic [7:0]        cfg_consmax_shift;
  logic [4:0]        lut_waddr;
  logic              lut_wen;
  logic [15:0]       lut_wdata;
  logic [GD*NH-1:0]  idata;
  logic [NH-1:0]     idata_valid;
  logic              lut_loaded;
  logic [4:0]        inflight;
  logic              err_underflow;

  consmax_seq_ctrl dut (
    .clk               (clk),
    .rstn              (rstn),
    .cfg_reload_req    (cfg_reload_req),
    .cfg_shift         (cfg_shift),
    .lut_in_data       (lut_in_data),
    .lut_in_valid      (lut_in_valid),
    .lut_in_ready      (lut_in_ready),
    .head_data         (head_data),
    .head_valid        (head_valid),
    .head_ready        (head_ready),
    .bus_odata_valid   (bus_odata_valid),
    .cfg_consmax_shift (cfg_consmax_shift),
    .lut_waddr         (lut_waddr),
    .lut_wen           (lut_wen),
    .lut_wdata         (lut_wdata),
    .idata             (idata),
    .idata_valid       (idata_valid),
    .lut_loaded        (lut_loaded),
    .inflight          (inflight),
    .err_underflow     (err_underflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_infl;
  logic        exp_err;
  logic [7:0]  cur_shift;
  logic [31:0] exp_idata [NH];
  logic [15:0] words [NE];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [GW*NH-1:0] lanes(input logic [NH-1:0] comp);
    logic [GW*NH-1:0] v;
    v = $urandom;
    for (int h = 0; h < NH; h++) v[h*GW] = comp[h];
    return v;
  endfunction

  task automatic do_reset();
    rstn = 1'b0; cfg_reload_req = 1'b0; lut_in_valid = 1'b0; head_valid = '0; bus_odata_valid = '0;
    tick(); tick();
    rstn = 1'b1;
    exp_infl = 0; exp_err = 1'b0; cur_shift = 8'h00;
    for (int h = 0; h < NH; h++) exp_idata[h] = '0;
  endtask

  task automatic check_reset_state();
    check("rst_lut_loaded", lut_loaded, 0);
    check("rst_inflight", inflight, 0);
    check("rst_err", err_underflow, 0);
    check("rst_lut_wen", lut_wen, 0);
    check("rst_shift", cfg_consmax_shift, 0);
    check("rst_head_ready", head_ready, 0);
    check("rst_lut_in_ready", lut_in_ready, 0);
    check("rst_idata_valid", idata_valid, 0);
    check("rst_idata", idata, 0);
  endtask

  task automatic reload_from_idle(input logic [7:0] shift);
    cfg_reload_req = 1'b1; cfg_shift = shift;
    tick();
    cfg_reload_req = 1'b0; cfg_shift = $urandom;
    cur_shift = shift;
    check("idle_load_shift", cfg_consmax_shift, shift);
    check("idle_load_ready", lut_in_ready, 1);
    check("idle_load_wen", lut_wen, 0);
  endtask

  // mode 0: valid every cycle, 1: valid toggling 1/0, 2: random valid
  task automatic load_stream(input int mode, input int limit);
    int   k;
    int   cyc;
    logic v;
    k = 0; cyc = 0;
    for (int i = 0; i < NE; i++) words[i] = 16'($urandom);
    while (k < limit && cyc < 300) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      check("load_in_ready", lut_in_ready, 1);
      check("load_head_ready", head_ready, 0);
      lut_in_valid = v;
      lut_in_data  = v ? words[k] : 16'($urandom);
      tick();
      check("load_wen", lut_wen, v);
      if (v) begin
        check("load_waddr", lut_waddr, k);
        check("load_wdata", lut_wdata, words[k]);
        k++;
      end
      check("load_loaded", lut_loaded, k == NE);
      check("load_shift", cfg_consmax_shift, cur_shift);
      cyc++;
    end
    lut_in_valid = 1'b0;
    check("load_count", k, limit);
    if (limit == NE) check("load_in_ready_after", lut_in_ready, 0);
  endtask

  task automatic run_step(input logic [NH-1:0] hv, input logic [NH-1:0] comp);
    logic          ready_exp;
    logic [NH-1:0] acc;
    ready_exp = (exp_infl + NH) <= MAXI;
    check("run_head_ready", head_ready, {NH{ready_exp}});
    acc = ready_exp ? hv : '0;
    for (int h = 0; h < NH; h++) begin
      head_data[h*GD +: GD] = $urandom;
      if (acc[h]) exp_idata[h] = head_data[h*GD +: GD];
    end
    head_valid = hv;
    bus_odata_valid = lanes(comp);
    tick();
    head_valid = '0; bus_odata_valid = '0;
    exp_infl = exp_infl + $countones(acc) - $countones(comp);
    if (exp_infl < 0) begin
      exp_infl = 0;
      exp_err  = 1'b1;
    end
    check("run_idata_valid", idata_valid, acc);
    check("run_inflight", inflight, exp_infl);
    check("run_err", err_underflow, exp_err);
    check("run_shift", cfg_consmax_shift, cur_shift);
    for (int h = 0; h < NH; h++) check("run_idata", idata[h*GD +: GD], exp_idata[h]);
  endtask

  task automatic drain_all();
    int guard;
    guard = 0;
    while (exp_infl > 0 && guard < 20) begin
      run_step('0, (exp_infl >= NH) ? {NH{1'b1}} : NH'((1 << exp_infl) - 1));
      guard++;
    end
  endtask

  task automatic reload_run(input logic [7:0] shift, input logic [NH-1:0] hv);
    logic          ready_exp;
    logic [NH-1:0] acc;
    logic [NH-1:0] last_acc;
    logic [NH-1:0] comp;
    logic          go;
    logic          done;
    int            cyc;
    ready_exp = (exp_infl + NH) <= MAXI;
    check("reload_ready_pre", head_ready, {NH{ready_exp}});
    acc = ready_exp ? hv : '0;
    for (int h = 0; h < NH; h++) begin
      head_data[h*GD +: GD] = $urandom;
      if (acc[h]) exp_idata[h] = head_data[h*GD +: GD];
    end
    head_valid = hv; cfg_reload_req = 1'b1; cfg_shift = shift;
    tick();
    head_valid = '0; cfg_reload_req = 1'b0; cfg_shift = $urandom;
    exp_infl = exp_infl + $countones(acc);
    check("reload_idata_valid", idata_valid, acc);
    check("reload_inflight", inflight, exp_infl);
    check("reload_loaded", lut_loaded, 0);
    check("reload_shift_old", cfg_consmax_shift, cur_shift);
    for (int h = 0; h < NH; h++) check("reload_idata", idata[h*GD +: GD], exp_idata[h]);
    last_acc = acc; done = 1'b0; cyc = 0;
    while (!done && cyc < 100) begin
      go = (exp_infl == 0) && (last_acc == '0);
      check("drain_head_ready", head_ready, 0);
      check("drain_in_ready", lut_in_ready, 0);
      comp = '0;
      if (!go && exp_infl > 0 && $urandom_range(0, 1) == 1) comp[$urandom_range(0, NH-1)] = 1'b1;
      bus_odata_valid = lanes(comp);
      head_valid = 8'($urandom);
      tick();
      bus_odata_valid = '0; head_valid = '0;
      exp_infl = exp_infl - $countones(comp);
      last_acc = '0;
      check("drain_wen", lut_wen, 0);
      check("drain_inflight", inflight, exp_infl);
      check("drain_idata_valid", idata_valid, 0);
      check("drain_to_load", lut_in_ready, go);
      check("drain_shift", cfg_consmax_shift, go ? shift : cur_shift);
      done = go; cyc++;
    end
    check("drain_bounded", done, 1);
    cur_shift = shift;
  endtask

  initial begin
    logic [NH-1:0] comp;
    int            nc;
    rstn = 1'b0; cfg_reload_req = 1'b0; cfg_shift = '0; lut_in_data = '0; lut_in_valid = 1'b0;
    head_data = '0; head_valid = '0; bus_odata_valid = '0;
    do_reset();
    check_reset_state();

    reload_from_idle(8'h05);
    load_stream(0, NE);

    // Credit limit: two full issues, then blocked; one completion keeps it blocked.
    run_step({NH{1'b1}}, '0);
    run_step({NH{1'b1}}, '0);
    run_step({NH{1'b1}}, '0);
    run_step('0, 8'h08);
    check("ready_at_15", head_ready, 0);
    drain_all();

    // Issue and completion of 3 beats in one cycle at inflight 4.
    run_step(8'h0f, '0);
    run_step(8'h70, 8'h07);
    check("net_out_4", inflight, 4);

    // Reload with nothing extra issued; toggling LUT stream.
    drain_all();
    reload_run(8'h33, '0);
    load_stream(1, NE);

    // Random traffic against the credit model.
    for (int i = 0; i < 150; i++) begin
      nc = $urandom_range(0, (exp_infl < 3) ? exp_infl : 3);
      comp = '0;
      while ($countones(comp) < nc) comp[$urandom_range(0, NH-1)] = 1'b1;
      run_step(8'($urandom), comp);
    end

    // Reload while 5 beats are issued in the request cycle.
    drain_all();
    reload_run(8'h5a, 8'h1f);
    load_stream(2, NE);

    // Completion with nothing in flight.
    run_step('0, 8'h01);
    check("underflow_flag", err_underflow, 1);
    run_step('0, '0);
    run_step(8'h03, '0);
    drain_all();

    // Reset in the middle of a LUT load.
    reload_run(8'h99, '0);
    load_stream(0, 10);
    do_reset();
    check_reset_state();
    tick();
    check_reset_state();
    reload_from_idle(8'h11);
    load_stream(2, NE);
    run_step({NH{1'b1}}, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
